// File: rtl/nvm_chan_pkg.sv
// Shared types for the NVM channel model: arbiter FSM states and the cell-voltage word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nvm_chan_pkg;

   // Arbiter sequencing: reseed the distortion RNG, serve requesters, or wait for in-flight words.
   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int CELL_W         = 32;
   localparam int VTH_W          = 16;
   localparam int VTH_PROG_LSB   = 16;
   localparam int VTH_ERASED_LSB = 0;

   // One cell word as carried on every requester lane and through the distortion pipeline.
   typedef struct packed {
      logic [VTH_W-1:0] vth_prog;
      logic [VTH_W-1:0] vth_erased;
   } cell_t;

   function automatic logic [VTH_W-1:0] vth_prog(input cell_t c);
      return c.vth_prog;
   endfunction

   function automatic logic [VTH_W-1:0] vth_erased(input cell_t c);
      return c.vth_erased;
   endfunction

endpackage

// File: rtl/rtn_result_fifo.sv
// Synchronous result FIFO with a registered first-word output and an occupancy count.
// Latency: a push into an empty FIFO appears on out_valid/out_data one cycle after the push edge.
// Backpressure: out_* hold while out_valid & !pop; the writer must never push into a full FIFO.
module rtn_result_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      mem_cnt;
   logic             load;

   // Refill the output register whenever it is empty or being consumed this cycle.
   assign load  = (mem_cnt != '0) && (!out_valid || pop);
   assign count = mem_cnt + {{AW{1'b0}}, out_valid};

   // Storage array: no reset needed, occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping for the storage array.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (load) rd_ptr <= rd_ptr + AW'(1);
         case ({push, load})
            2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
            2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
            default: mem_cnt <= mem_cnt;
         endcase
      end
   end

   // Registered head word, held stable until popped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= mem[rd_ptr];
      end else if (pop) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rtn_channel_arbiter.sv
// Shares one fixed-latency RTN distortion pipeline among NUM_REQ cell streams; reseeds, round-robin arbitrates, tags and returns results with requester ID.
// Latency: handshake edge to rsp_valid is DP_LAT+2 cycles when the result FIFO is empty.
// Backpressure: credit admission (outstanding < FIFO_DEPTH) so the pipeline never stalls; rsp_ready=0 fills the FIFO and then closes grants.
// Build option: define RTN_ARB_STATS_EN to add the stat_grants / stat_stall counter outputs.
module rtn_channel_arbiter
   import nvm_chan_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DP_LAT      = 2,
   parameter int FIFO_DEPTH  = 8,
   parameter int SEED_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [CELL_W*NUM_REQ-1:0]     req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          flush,
   output logic                          dp_seed_load,
   output logic                          dp_in_valid,
   output logic [CELL_W-1:0]             dp_in_data,
   input  logic [CELL_W-1:0]             dp_out_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [CELL_W-1:0]             rsp_data,
   output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
   output logic                          busy
`ifdef RTN_ARB_STATS_EN
   ,
   output logic [32*NUM_REQ-1:0]         stat_grants,
   output logic [31:0]                   stat_stall
`endif
);

   localparam int ID_W     = $clog2(NUM_REQ);
   localparam int INIT_LEN = SEED_CYCLES + DP_LAT;
   localparam int CNT_W    = $clog2(INIT_LEN + 1);
   localparam int OUT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int FCNT_W   = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  init_cnt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   cand;
   logic              win_found;
   logic              grant_en;
   logic              accept;
   logic              pop;
   logic [OUT_W-1:0]  outstanding;
   cell_t             issue_word;

   logic [DP_LAT:0]   tag_vld;
   logic [ID_W-1:0]   tag_id [DP_LAT+1];

   logic [FCNT_W-1:0]    fifo_count;
   logic [ID_W+CELL_W-1:0] fifo_out;

   assign accept     = grant_en && win_found;
   assign pop        = rsp_valid && rsp_ready;
   assign issue_word = req_data[CELL_W*win_id +: CELL_W];
   assign rsp_id     = fifo_out[ID_W+CELL_W-1:CELL_W];
   assign rsp_data   = fifo_out[CELL_W-1:0];

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= INIT;
      else       state <= state_nxt;
   end

   // FSM next state and grant enable; flush closes grants in the very cycle it is seen.
   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      case (state)
         INIT:    if (init_cnt == CNT_W'(INIT_LEN - 1)) state_nxt = RUN;
         RUN: begin
            if (flush) state_nxt = DRAIN;
            else       grant_en  = (outstanding < OUT_W'(FIFO_DEPTH));
         end
         DRAIN:   if (outstanding == '0) state_nxt = INIT;
         default: state_nxt = INIT;
      endcase
   end

   // INIT dwell counter: restarts from zero every time INIT is entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)               init_cnt <= '0;
      else if (state != INIT)  init_cnt <= '0;
      else                     init_cnt <= init_cnt + CNT_W'(1);
   end

   // Round-robin search starting one past the last winner.
   always_comb begin
      win_found = 1'b0;
      win_id    = rr_ptr;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // One-hot grant, only while admission is open.
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_id] = 1'b1;
   end

   // Pointer moves to the winner only when a word is actually taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       rr_ptr <= ID_W'(NUM_REQ - 1);
      else if (accept) rr_ptr <= win_id;
   end

   // Credit count: words accepted but not yet popped by the consumer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Issue register towards the distortion pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_in_valid <= 1'b0;
         dp_in_data  <= '0;
      end else begin
         dp_in_valid <= accept;
         if (accept) dp_in_data <= issue_word;
      end
   end

   // Tag shift register: its tail lines up with dp_out_data for the same word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld <= '0;
         for (int i = 0; i <= DP_LAT; i++) tag_id[i] <= '0;
      end else begin
         tag_vld[0] <= accept;
         tag_id[0]  <= win_id;
         for (int i = 1; i <= DP_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
      end
   end

   // Seed strobe and busy are registered so every output is quiet while reset is held;
   // the strobe coincides with busy rising and marks the first clocked INIT cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_seed_load <= 1'b0;
         busy         <= 1'b0;
      end else begin
         dp_seed_load <= (state == INIT) && (init_cnt == '0);
         busy         <= (state != RUN) || (outstanding != '0) || (fifo_count != '0);
      end
   end

   rtn_result_fifo #(
      .WIDTH (ID_W + CELL_W),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tag_vld[DP_LAT]),
      .push_data ({tag_id[DP_LAT], dp_out_data}),
      .pop       (pop),
      .out_valid (rsp_valid),
      .out_data  (fifo_out),
      .count     (fifo_count)
   );

`ifdef RTN_ARB_STATS_EN
   // Per-requester accepted-word counters and a stall counter; both wrap and clear only on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_grants <= '0;
         stat_stall  <= '0;
      end else begin
         if (accept) stat_grants[32*win_id +: 32] <= stat_grants[32*win_id +: 32] + 32'd1;
         if ((|req_valid) && !accept) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
